// File: rtl/usr_access_stamp.sv
// Brings the configuration user-access word into the system clock domain, qualifies it
// as a stable build stamp, decodes its timestamp fields and serves them over a read port.
module usr_access_stamp #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] usr_data,
    input  logic        usr_datavalid,
    input  logic        rd_req,
    input  logic [2:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_ack,
    output logic        stamp_valid,
    output logic        stamp_changed,
    output logic [7:0]  glitch_count
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_QUAL   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Two-flop synchronizer; the word only matters once it has been stable for a
    // long run, so a torn multi-bit capture simply restarts qualification.
    logic [31:0] sync1_data_q, s_data_q;
    logic        sync1_valid_q, s_valid_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_data_q  <= '0;
            s_data_q      <= '0;
            sync1_valid_q <= 1'b0;
            s_valid_q     <= 1'b0;
        end else begin
            sync1_data_q  <= usr_data;
            s_data_q      <= sync1_data_q;
            sync1_valid_q <= usr_datavalid;
            s_valid_q     <= sync1_valid_q;
        end
    end

    state_t        state_q;
    logic [31:0]   cand_q;
    logic [31:0]   stamp_q;
    logic [CW-1:0] cnt_q;
    logic          stamp_valid_q;
    logic          stamp_changed_q;
    logic          has_commit_q;
    logic [7:0]    glitch_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= ST_WAIT;
            cand_q          <= '0;
            stamp_q         <= '0;
            cnt_q           <= '0;
            stamp_valid_q   <= 1'b0;
            stamp_changed_q <= 1'b0;
            has_commit_q    <= 1'b0;
            glitch_q        <= '0;
        end else begin
            stamp_changed_q <= 1'b0;
            case (state_q)
                ST_WAIT: begin
                    if (s_valid_q) begin
                        cand_q  <= s_data_q;
                        cnt_q   <= CW'(1);
                        state_q <= ST_QUAL;
                    end
                end
                ST_QUAL: begin
                    if (!s_valid_q) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= '0;
                    end else if (s_data_q != cand_q) begin
                        cand_q <= s_data_q;
                        cnt_q  <= CW'(1);
                        if (glitch_q != 8'hFF) begin
                            glitch_q <= glitch_q + 8'd1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        stamp_q         <= cand_q;
                        stamp_valid_q   <= 1'b1;
                        has_commit_q    <= 1'b1;
                        stamp_changed_q <= has_commit_q && (cand_q != stamp_q);
                        state_q         <= ST_LOCKED;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_LOCKED: begin
                    // A new word leaving LOCKED is a rebuild, not a glitch.
                    if (!s_valid_q) begin
                        state_q       <= ST_WAIT;
                        stamp_valid_q <= 1'b0;
                    end else if (s_data_q != stamp_q) begin
                        cand_q        <= s_data_q;
                        cnt_q         <= CW'(1);
                        stamp_valid_q <= 1'b0;
                        state_q       <= ST_QUAL;
                    end
                end
                default: state_q <= ST_WAIT;
            endcase
        end
    end

    logic [31:0] rd_data_d;

    always_comb begin
        rd_data_d = '0;
        case (rd_addr)
            3'd0: rd_data_d = stamp_q;
            3'd1: rd_data_d = {26'b0, stamp_q[5:0]};
            3'd2: rd_data_d = {26'b0, stamp_q[11:6]};
            3'd3: rd_data_d = {27'b0, stamp_q[16:12]};
            3'd4: rd_data_d = {27'b0, stamp_q[31:27]};
            3'd5: rd_data_d = {28'b0, stamp_q[26:23]};
            3'd6: rd_data_d = {20'b0, 12'd2000 + {6'b0, stamp_q[22:17]}};
            3'd7: rd_data_d = {16'b0, glitch_q, 5'b0, state_q, stamp_valid_q};
            default: rd_data_d = '0;
        endcase
    end

    logic [31:0] rd_data_q;
    logic        rd_ack_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_data_q <= '0;
            rd_ack_q  <= 1'b0;
        end else begin
            rd_ack_q  <= rd_req;
            rd_data_q <= rd_req ? rd_data_d : '0;
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_ack        = rd_ack_q;
    assign stamp_valid   = stamp_valid_q;
    assign stamp_changed = stamp_changed_q;
    assign glitch_count  = glitch_q;

endmodule

// File: tb/tb_usr_access_stamp.sv
// Directed bench for usr_access_stamp: read responses are checked by a monitor against
// an expected queue; qualification timing and status outputs are checked inline.
module tb_usr_access_stamp;

  localparam logic [31:0] STAMP_A = 32'h7B30DB5E;
  localparam logic [31:0] STAMP_B = 32'h7B30DB5F;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] usr_data;
  logic        usr_datavalid;
  logic        rd_req;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_ack;
  logic        stamp_valid;
  logic        stamp_changed;
  logic [7:0]  glitch_count;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  usr_access_stamp #(.STABLE_CYCLES(16)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .usr_data      (usr_data),
    .usr_datavalid (usr_datavalid),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_ack        (rd_ack),
    .stamp_valid   (stamp_valid),
    .stamp_changed (stamp_changed),
    .glitch_count  (glitch_count)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One read per call; the expected response goes to the scoreboard queue.
  task automatic issue_read(input logic [2:0] addr, input logic [31:0] exp);
    rd_req  = 1'b1;
    rd_addr = addr;
    exp_q.push_back(exp);
    @(negedge clock);
    rd_req  = 1'b0;
  endtask

  // Monitor: acked reads pop the queue, idle cycles must return zero data.
  always @(negedge clock) begin
    if (reset_n === 1'b1 || reset_n === 1'b0) begin
      if (rd_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: got ack with data %h, expected no ack", rd_data);
        end else begin
          check("rd_data", rd_data, exp_q.pop_front());
        end
      end else begin
        check("rd_idle_zero", rd_data, 32'h0);
      end
    end
  end

  initial begin
    reset_n       = 1'b0;
    usr_data      = 32'h0;
    usr_datavalid = 1'b0;
    rd_req        = 1'b0;
    rd_addr       = 3'd0;
    tick(3);
    check("reset_stamp_valid", {31'b0, stamp_valid}, 32'h0);
    check("reset_stamp_changed", {31'b0, stamp_changed}, 32'h0);
    check("reset_glitch", {24'b0, glitch_count}, 32'h0);
    check("reset_rd_ack", {31'b0, rd_ack}, 32'h0);
    reset_n = 1'b1;
    tick(1);

    // First qualification: sample seen at edge 2, 16th matching sample commits at edge 17.
    usr_data      = STAMP_A;
    usr_datavalid = 1'b1;
    tick(17);
    check("first_commit_not_early", {31'b0, stamp_valid}, 32'h0);
    tick(1);
    check("first_commit_valid", {31'b0, stamp_valid}, 32'h1);
    check("first_commit_no_pulse", {31'b0, stamp_changed}, 32'h0);
    for (int a = 0; a < 8; a++) begin
      logic [31:0] e;
      case (a)
        0: e = STAMP_A;
        1: e = 32'd30;
        2: e = 32'd45;
        3: e = 32'd13;
        4: e = 32'd15;
        5: e = 32'd6;
        6: e = 32'h7E8;
        default: e = 32'h5;
      endcase
      rd_req  = 1'b1;
      rd_addr = a[2:0];
      exp_q.push_back(e);
      @(negedge clock);
    end
    rd_req = 1'b0;
    tick(2);

    // Drop valid while locked: stamp retained, state back to WAIT.
    usr_datavalid = 1'b0;
    tick(2);
    check("drop_valid_not_early", {31'b0, stamp_valid}, 32'h1);
    tick(1);
    check("drop_valid_low", {31'b0, stamp_valid}, 32'h0);
    issue_read(3'd7, 32'h0);
    issue_read(3'd0, STAMP_A);
    tick(2);

    // Glitch during QUAL: two changes, commit 16 samples after the last one.
    usr_data      = STAMP_A;
    usr_datavalid = 1'b1;
    tick(4);
    usr_data = 32'h1;
    tick(3);
    usr_data = STAMP_A;
    tick(17);
    check("glitch_commit_not_early", {31'b0, stamp_valid}, 32'h0);
    tick(1);
    check("glitch_commit_valid", {31'b0, stamp_valid}, 32'h1);
    check("same_stamp_no_pulse", {31'b0, stamp_changed}, 32'h0);
    check("glitch_count_two", {24'b0, glitch_count}, 32'd2);
    issue_read(3'd7, 32'h0000_0205);
    tick(2);

    // New build stamp from LOCKED: not a glitch, pulse on recommit.
    usr_data = STAMP_B;
    tick(2);
    check("change_not_early", {31'b0, stamp_valid}, 32'h1);
    tick(1);
    check("change_valid_low", {31'b0, stamp_valid}, 32'h0);
    tick(15);
    check("recommit_valid", {31'b0, stamp_valid}, 32'h1);
    check("recommit_pulse", {31'b0, stamp_changed}, 32'h1);
    tick(1);
    check("pulse_one_cycle", {31'b0, stamp_changed}, 32'h0);
    check("no_glitch_on_change", {24'b0, glitch_count}, 32'd2);
    issue_read(3'd1, 32'd31);
    issue_read(3'd0, STAMP_B);
    tick(2);

    // Saturation: toggle every cycle well past 255 restarts.
    for (int i = 0; i < 300; i++) begin
      usr_data = i[0] ? 32'hAAAA_0000 : 32'h5555_0000;
      tick(1);
    end
    check("glitch_saturated", {24'b0, glitch_count}, 32'd255);
    issue_read(3'd7, 32'h0000_FF02);
    tick(1);

    // Reset mid-QUAL with reads pending: reads during reset are never acked.
    usr_datavalid = 1'b0;
    reset_n = 1'b0;
    rd_req  = 1'b1;
    rd_addr = 3'd7;
    tick(1);
    check("rst_ack", {31'b0, rd_ack}, 32'h0);
    check("rst_data", rd_data, 32'h0);
    check("rst_stamp_valid", {31'b0, stamp_valid}, 32'h0);
    check("rst_glitch", {24'b0, glitch_count}, 32'h0);
    tick(1);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [2:0] a;
      case (i)
        0: a = 3'd0;
        1: a = 3'd7;
        2: a = 3'd1;
        3: a = 3'd6;
        4: a = 3'd5;
        default: a = 3'd4;
      endcase
      rd_req  = 1'b1;
      rd_addr = a;
      exp_q.push_back(a == 3'd6 ? 32'd2000 : 32'h0);
      @(negedge clock);
    end
    rd_req = 1'b0;
    tick(3);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_acks: got %0d reads unanswered, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
